memio_bridge: RTL and testbench
===============================

# memio_bridge

Parametrised successor to the single-cycle datapath's combinational memory-or-IO selector. It sits between the decoder/ALU/controller and both the data memory and up to `IO_CH` peripheral channels. Memory accesses pass through with no added latency. IO accesses become a registered request/acknowledge transaction per channel, with a `stall` output that holds the PC, optional timeout, and a sticky bus-error flag.

## Interface
- `DATA_W`, 32, data width of memory, register file and IO channels
- `ADDR_W`, 32, width of `addr_in`
- `IO_CH`, 4, number of IO channels (1..16)
- `TIMEOUT`, 15, cycles an IO request waits for `ch_ack` before aborting (1..255)

Ports:
- `clock`  in  1  CPU clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `m_read`, `m_write`, `io_read`, `io_write`  in  1 each  access strobes from controller
- `addr_in`  in  ADDR_W  ALU result address
- `r_rdata`  in  DATA_W  store data from register file
- `r_wdata`  out  DATA_W  load data to register file
- `stall`  out  1  hold PC and suppress register write while high
- `mem_addr`  out  ADDR_W  data memory address
- `mem_wdata`  out  DATA_W  data memory write data
- `mem_we`  out  1  data memory write enable
- `mem_rdata`  in  DATA_W  data memory read data
- `ch_req`  out  IO_CH  one-hot request, registered
- `ch_we`  out  1  request is a write, registered
- `ch_addr`  out  4  register offset `addr_in[3:0]`, registered
- `ch_wdata`  out  DATA_W  write data, registered
- `ch_ack`  in  IO_CH  per-channel acknowledge
- `ch_rdata`  in  IO_CH*DATA_W  flattened read data; channel k at bits [k*DATA_W +: DATA_W]
- `bus_err`  out  1  sticky error flag
- `err_ch`  out  4  channel index of the first error

## Operation
- IO region: `addr_in[ADDR_W-1:10]` all ones. Channel select `sel = addr_in[7:4]`.
- Memory path is combinational: `mem_addr=addr_in`, `mem_wdata=r_rdata`, `mem_we=m_write & ~io_write`. If `m_read` is high and the FSM is in IDLE, `r_wdata=mem_rdata`.
- If IO and memory strobes are both high, IO wins. If read and write are both high, write wins.
- FSM states:
  - IDLE: on `io_read|io_write`, latch `sel`, offset, write data and direction.
    - `sel<IO_CH` → REQ.
    - `sel>=IO_CH` → DONE with data 0; set `bus_err` and `err_ch` if not already set.
  - REQ: `ch_req[sel]=1`.
    - On `ch_ack[sel]`: capture `ch_rdata[sel]` (reads only), drop `ch_req` at the next edge, → DONE.
    - Acks from other channels are ignored.
  - DONE: lasts one cycle, then → IDLE unconditionally.
- Abort (timeout, see Configuration): → DONE, read data `{DATA_W{1'b0}}`, `bus_err` set.
- `stall = (IDLE & (io_read|io_write)) | REQ`. It is low in DONE, so the CPU commits `r_wdata` on the edge leaving DONE. `r_wdata` in DONE is the captured data; for writes it is 0.
- `bus_err` and `err_ch` hold until reset. A later error does not overwrite `err_ch`.

## Timing
- All outputs at reset: state IDLE, `ch_req=0`, `ch_we=0`, `ch_addr=0`, `ch_wdata=0`, captured data 0, `bus_err=0`, `err_ch=0`, timeout counter 0.
- `stall` is gated low while `rst` is high.
- Minimum IO latency: 2 stall cycles. Example: the strobe is seen in cycle 0, REQ runs in cycle 1 with `ch_ack` in the same cycle, and `r_wdata` is valid in cycle 2 (DONE).
- Each extra cycle without ack adds one stall cycle.
- Peripherals may hold `ch_ack` high continuously. Only the first ack in REQ is used.
- Reset mid-REQ: `ch_req` drops asynchronously. No DONE cycle occurs and no error is flagged.
- Memory accesses never stall.

## Configuration
- `MEMIO_TIMEOUT_EN` defined: an 8-bit counter clears on REQ entry and increments each REQ cycle without ack.
  - When the counter reaches `TIMEOUT` the request is aborted as above.
  - `err_ch=sel` is recorded if this is the first error.
- Not defined: no counter. REQ waits indefinitely for ack; `bus_err` is set only by invalid channel selects.

## Structure
- Package `memio_pkg`: state enum (IDLE/REQ/DONE), `IO_REGION_HI` constant (22 ones), channel-select bit positions, `ERR_RDATA` (zero).
- One sub-module, `io_timeout_ctr` (clear, enable, hit output).
  - Instantiated only under `MEMIO_TIMEOUT_EN`.

## Test plan
- Memory load: `m_read=1`, `addr_in=0x10`, `mem_rdata=0x1234` → `r_wdata=0x1234` same cycle, `stall=0`.
- IO read, channel 2 (`addr_in=0xFFFFFC24`), ack on first REQ cycle with data 0xABCD → `ch_req=4'b0100` for 1 cycle, `ch_addr=4`, `stall` high 2 cycles, `r_wdata=0xABCD` in DONE.
- IO write, channel 1, ack delayed 3 cycles, `r_rdata=0x55` → `ch_we=1`, `ch_wdata=0x55`, `ch_req` high 4 cycles, `stall` high 5 cycles, `mem_we=0` throughout.
- Invalid channel (`sel=5`, `IO_CH=4`) → DONE next cycle, `r_wdata=0`, `bus_err=1`, `err_ch=5`. A later timeout keeps `err_ch=5`.
- With `MEMIO_TIMEOUT_EN`, `TIMEOUT=15`, no ack on channel 3 → abort after 15 REQ cycles, `r_wdata=0`, `bus_err=1`, `err_ch=3`. Without the macro, `stall` stays high.
- Assert `rst` during REQ → `ch_req=0` and `stall=0` immediately; after release, state is IDLE and `bus_err=0`.

Source files
------------

// File: rtl/memio_pkg.sv
// memio_pkg -- shared types and constants for the memory/IO bridge.
//   state_e        : IO transaction FSM states (IDLE, REQ, DONE)
//   IO_REGION_HI   : address bits [31:10] of the IO window (all ones)
//   SEL_MSB/LSB    : channel-select field inside addr_in
//   OFF_MSB/LSB    : register-offset field inside addr_in
//   ERR_RDATA_BIT  : fill bit for read data returned on an error/abort
//   TMO_CNT_W      : width of the optional timeout counter
package memio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [21:0] IO_REGION_HI = '1;

  localparam int SEL_LSB = 4;
  localparam int SEL_MSB = 7;
  localparam int OFF_LSB = 0;
  localparam int OFF_MSB = 3;

  localparam logic ERR_RDATA_BIT = 1'b0;

  localparam int TMO_CNT_W = 8;

endpackage

// File: rtl/io_timeout_ctr.sv
// io_timeout_ctr -- 8-bit cycle counter that aborts a stuck IO request.
// Ports:
//   clock   : rising-edge clock
//   rst     : asynchronous active-high reset (counter -> 0)
//   clr_i   : clear on entry into REQ
//   en_i    : count one REQ cycle that saw no acknowledge
//   hit_o   : high in the REQ cycle whose count brings the counter to LIMIT,
//             so the request is aborted after exactly LIMIT waiting cycles
module io_timeout_ctr
  import memio_pkg::*;
#(
  parameter int LIMIT = 15
) (
  input  logic clock,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic hit_o
);

  logic [TMO_CNT_W-1:0] cnt_q;
  logic [TMO_CNT_W-1:0] cnt_d;

  // NOTE: a combinational block must assign every output on every path;
  // the leading default prevents an inferred latch.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit_o = en_i && (cnt_q + 1'b1 == TMO_CNT_W'(LIMIT));

endmodule

// File: rtl/memio_bridge.sv
// memio_bridge -- routes CPU data accesses to data memory (combinational,
// zero latency) or to one of IO_CH peripheral channels through a registered
// request/acknowledge handshake that stalls the CPU until it completes.
// Ports:
//   clock, rst                          : clock, async active-high reset
//   m_read/m_write/io_read/io_write     : access strobes (IO beats memory,
//                                         write beats read)
//   addr_in, r_rdata / r_wdata          : address, store data / load data
//   stall                               : hold PC, suppress register write
//   mem_addr/mem_wdata/mem_we/mem_rdata : data memory port
//   ch_req/ch_we/ch_addr/ch_wdata       : registered channel request
//   ch_ack/ch_rdata                     : per-channel ack and flattened data
//   bus_err/err_ch                      : sticky error flag, first bad channel
// Optional feature: define MEMIO_TIMEOUT_EN to abort requests that receive no
// acknowledge within TIMEOUT cycles.
module memio_bridge
  import memio_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int IO_CH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                    clock,
  input  logic                    rst,
  input  logic                    m_read,
  input  logic                    m_write,
  input  logic                    io_read,
  input  logic                    io_write,
  input  logic [ADDR_W-1:0]       addr_in,
  input  logic [DATA_W-1:0]       r_rdata,
  output logic [DATA_W-1:0]       r_wdata,
  output logic                    stall,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [DATA_W-1:0]       mem_wdata,
  output logic                    mem_we,
  input  logic [DATA_W-1:0]       mem_rdata,
  output logic [IO_CH-1:0]        ch_req,
  output logic                    ch_we,
  output logic [3:0]              ch_addr,
  output logic [DATA_W-1:0]       ch_wdata,
  input  logic [IO_CH-1:0]        ch_ack,
  input  logic [IO_CH*DATA_W-1:0] ch_rdata,
  output logic                    bus_err,
  output logic [3:0]              err_ch
);

  state_e              state_q;
  logic [3:0]          sel_q;
  logic [IO_CH-1:0]    ch_req_q;
  logic                ch_we_q;
  logic [3:0]          ch_addr_q;
  logic [DATA_W-1:0]   ch_wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                bus_err_q;
  logic [3:0]          err_ch_q;

  logic                io_strobe;
  logic [3:0]          sel_in;
  logic                sel_valid;
  logic [IO_CH-1:0]    sel_onehot;
  logic                ack_sel;
  logic [DATA_W-1:0]   ack_rdata;
  logic                abort;

  assign io_strobe  = io_read | io_write;
  assign sel_in     = addr_in[SEL_MSB:SEL_LSB];
  assign sel_valid  = int'(sel_in) < IO_CH;
  assign sel_onehot = IO_CH'(1) << sel_in;

  // ch_req_q is one-hot on the selected channel, so masking the acks with it
  // ignores acknowledges from every other channel.
  assign ack_sel = |(ch_ack & ch_req_q);

  always_comb begin
    ack_rdata = '0;
    for (int k = 0; k < IO_CH; k++) begin
      if (ch_req_q[k]) begin
        ack_rdata = ch_rdata[k*DATA_W +: DATA_W];
      end
    end
  end

`ifdef MEMIO_TIMEOUT_EN
  io_timeout_ctr #(
    .LIMIT (TIMEOUT)
  ) u_timeout (
    .clock (clock),
    .rst   (rst),
    .clr_i ((state_q == ST_IDLE) && io_strobe && sel_valid),
    .en_i  ((state_q == ST_REQ) && !ack_sel),
    .hit_o (abort)
  );
`else
  logic unused_no_timeout;
  assign unused_no_timeout = ^{sel_q, 8'(TIMEOUT)};
  assign abort = 1'b0;
`endif

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      sel_q      <= '0;
      ch_req_q   <= '0;
      ch_we_q    <= 1'b0;
      ch_addr_q  <= '0;
      ch_wdata_q <= '0;
      rdata_q    <= '0;
      bus_err_q  <= 1'b0;
      err_ch_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (io_strobe) begin
            sel_q      <= sel_in;
            ch_addr_q  <= addr_in[OFF_MSB:OFF_LSB];
            ch_wdata_q <= r_rdata;
            ch_we_q    <= io_write;
            rdata_q    <= '0;
            if (sel_valid) begin
              ch_req_q <= sel_onehot;
              state_q  <= ST_REQ;
            end else begin
              state_q <= ST_DONE;
              if (!bus_err_q) begin
                bus_err_q <= 1'b1;
                err_ch_q  <= sel_in;
              end
            end
          end
        end
        ST_REQ: begin
          if (ack_sel) begin
            ch_req_q <= '0;
            if (!ch_we_q) begin
              rdata_q <= ack_rdata;
            end
            state_q <= ST_DONE;
          end else if (abort) begin
            ch_req_q <= '0;
            rdata_q  <= {DATA_W{ERR_RDATA_BIT}};
            state_q  <= ST_DONE;
            if (!bus_err_q) begin
              bus_err_q <= 1'b1;
              err_ch_q  <= sel_q;
            end
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Memory path: pure pass-through; an IO write suppresses the memory write.
  assign mem_addr  = addr_in;
  assign mem_wdata = r_rdata;
  assign mem_we    = m_write & ~io_write;

  always_comb begin
    r_wdata = '0;
    if (state_q == ST_DONE) begin
      r_wdata = rdata_q;
    end else if (state_q == ST_IDLE && m_read && !io_strobe) begin
      r_wdata = mem_rdata;
    end
  end

  // Low in DONE so the CPU commits r_wdata on the edge that leaves DONE.
  assign stall = ~rst & (((state_q == ST_IDLE) & io_strobe) | (state_q == ST_REQ));

  assign ch_req   = ch_req_q;
  assign ch_we    = ch_we_q;
  assign ch_addr  = ch_addr_q;
  assign ch_wdata = ch_wdata_q;
  assign bus_err  = bus_err_q;
  assign err_ch   = err_ch_q;

endmodule

// File: tb/tb_memio_bridge.sv
// tb_memio_bridge -- directed self-checking bench for memio_bridge
// (default parameters: DATA_W=32, ADDR_W=32, IO_CH=4, TIMEOUT=15).
// Inputs change 1 time unit after a rising edge; outputs are sampled 1 time
// unit after that, well clear of the next edge.
module tb_memio_bridge;

  logic          clock = 1'b0;
  logic          rst;
  logic          m_read, m_write, io_read, io_write;
  logic [31:0]   addr_in;
  logic [31:0]   r_rdata;
  logic [31:0]   r_wdata;
  logic          stall;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_we;
  logic [31:0]   mem_rdata;
  logic [3:0]    ch_req;
  logic          ch_we;
  logic [3:0]    ch_addr;
  logic [31:0]   ch_wdata;
  logic [3:0]    ch_ack;
  logic [127:0]  ch_rdata;
  logic          bus_err;
  logic [3:0]    err_ch;

  int n_checks = 0;
  int n_fail   = 0;

  memio_bridge #(
    .DATA_W (32), .ADDR_W (32), .IO_CH (4), .TIMEOUT (15)
  ) dut (
    .clock     (clock),
    .rst       (rst),
    .m_read    (m_read),
    .m_write   (m_write),
    .io_read   (io_read),
    .io_write  (io_write),
    .addr_in   (addr_in),
    .r_rdata   (r_rdata),
    .r_wdata   (r_wdata),
    .stall     (stall),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata),
    .ch_req    (ch_req),
    .ch_we     (ch_we),
    .ch_addr   (ch_addr),
    .ch_wdata  (ch_wdata),
    .ch_ack    (ch_ack),
    .ch_rdata  (ch_rdata),
    .bus_err   (bus_err),
    .err_ch    (err_ch)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    m_read = 0; m_write = 0; io_read = 0; io_write = 0;
    addr_in = '0; r_rdata = '0; mem_rdata = '0; ch_ack = '0; ch_rdata = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    io_read = 1'b1; addr_in = 32'hFFFF_FC24;
    #3;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall_gated: got %b want 0", stall); end
    n_checks++; if (ch_req !== 4'b0000) begin n_fail++; $display("FAIL rst_ch_req: got %b want 0000", ch_req); end
    n_checks++; if ({ch_we, ch_addr, ch_wdata} !== 37'd0) begin n_fail++; $display("FAIL rst_ch_regs: got %h want 0", {ch_we, ch_addr, ch_wdata}); end
    n_checks++; if ({bus_err, err_ch} !== 5'd0) begin n_fail++; $display("FAIL rst_err: got %b want 00000", {bus_err, err_ch}); end
    io_read = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    n_checks++; if ({stall, r_wdata} !== 33'd0) begin n_fail++; $display("FAIL rst_idle_out: got %h want 0", {stall, r_wdata}); end
  endtask

  task automatic test_mem_access();
    m_read = 1; addr_in = 32'h10; mem_rdata = 32'h1234;
    #1;
    n_checks++; if (r_wdata !== 32'h1234) begin n_fail++; $display("FAIL mem_load_data: got %h want 00001234", r_wdata); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL mem_load_stall: got %b want 0", stall); end
    n_checks++; if (mem_addr !== 32'h10) begin n_fail++; $display("FAIL mem_addr: got %h want 00000010", mem_addr); end
    tick();
    m_read = 0; m_write = 1; addr_in = 32'h44; r_rdata = 32'hCAFE;
    #1;
    n_checks++; if ({mem_we, mem_wdata} !== {1'b1, 32'hCAFE}) begin n_fail++; $display("FAIL mem_store: got %h want 10000cafe", {mem_we, mem_wdata}); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL mem_store_stall: got %b want 0", stall); end
    tick();
    idle_inputs();
  endtask

  task automatic test_io_read();
    io_read = 1; addr_in = 32'hFFFF_FC24;
    #1;
    n_checks++; if ({stall, ch_req} !== 5'b1_0000) begin n_fail++; $display("FAIL rd_c0: got stall/req %b want 10000", {stall, ch_req}); end
    tick();
    ch_ack = 4'b0100; ch_rdata[2*32 +: 32] = 32'hABCD;
    #1;
    n_checks++; if ({stall, ch_req} !== 5'b1_0100) begin n_fail++; $display("FAIL rd_req: got stall/req %b want 10100", {stall, ch_req}); end
    n_checks++; if ({ch_we, ch_addr} !== 5'b0_0100) begin n_fail++; $display("FAIL rd_we_addr: got %b want 00100", {ch_we, ch_addr}); end
    tick();
    ch_ack = 4'b0000;
    #1;
    n_checks++; if ({stall, ch_req} !== 5'b0_0000) begin n_fail++; $display("FAIL rd_done_ctl: got stall/req %b want 00000", {stall, ch_req}); end
    n_checks++; if (r_wdata !== 32'hABCD) begin n_fail++; $display("FAIL rd_done_data: got %h want 0000abcd", r_wdata); end
    tick();
    idle_inputs();
    #1;
    n_checks++; if ({stall, ch_req} !== 5'b0_0000) begin n_fail++; $display("FAIL rd_after: got stall/req %b want 00000", {stall, ch_req}); end
  endtask

  task automatic test_io_write();
    io_write = 1; m_write = 1; addr_in = 32'hFFFF_FC18; r_rdata = 32'h55;
    #1;
    n_checks++; if ({stall, mem_we} !== 2'b10) begin n_fail++; $display("FAIL wr_c0: got stall/mem_we %b want 10", {stall, mem_we}); end
    for (int c = 1; c <= 4; c++) begin
      tick();
      ch_ack = (c == 2) ? 4'b0001 : (c == 4) ? 4'b0010 : 4'b0000;
      #1;
      n_checks++; if ({stall, mem_we, ch_req} !== 6'b10_0010) begin n_fail++; $display("FAIL wr_req_c%0d: got stall/mem_we/req %b want 100010", c, {stall, mem_we, ch_req}); end
      n_checks++; if ({ch_we, ch_addr, ch_wdata} !== {1'b1, 4'h8, 32'h55}) begin n_fail++; $display("FAIL wr_payload_c%0d: got %h want 1800000055", c, {ch_we, ch_addr, ch_wdata}); end
    end
    tick();
    ch_ack = 4'b0000;
    #1;
    n_checks++; if ({stall, mem_we, ch_req} !== 6'b00_0000) begin n_fail++; $display("FAIL wr_done_ctl: got %b want 000000", {stall, mem_we, ch_req}); end
    n_checks++; if (r_wdata !== 32'h0) begin n_fail++; $display("FAIL wr_done_data: got %h want 00000000", r_wdata); end
    tick();
    idle_inputs();
  endtask

  // Acks held high; two back-to-back reads each use only the first ack.
  task automatic test_back_to_back();
    ch_ack = 4'b1111;
    ch_rdata[0 +: 32] = 32'h11; ch_rdata[3*32 +: 32] = 32'h33;
    io_read = 1; addr_in = 32'hFFFF_FC00;
    tick();
    #1;
    n_checks++; if ({stall, ch_req} !== 5'b1_0001) begin n_fail++; $display("FAIL b2b_req0: got %b want 10001", {stall, ch_req}); end
    tick();
    n_checks++; if ({stall, r_wdata} !== {1'b0, 32'h11}) begin n_fail++; $display("FAIL b2b_done0: got %h want 000000011", {stall, r_wdata}); end
    tick();
    addr_in = 32'hFFFF_FC30;
    #1;
    n_checks++; if ({stall, ch_req} !== 5'b1_0000) begin n_fail++; $display("FAIL b2b_idle1: got %b want 10000", {stall, ch_req}); end
    tick();
    n_checks++; if ({stall, ch_req} !== 5'b1_1000) begin n_fail++; $display("FAIL b2b_req1: got %b want 11000", {stall, ch_req}); end
    tick();
    n_checks++; if ({stall, r_wdata} !== {1'b0, 32'h33}) begin n_fail++; $display("FAIL b2b_done1: got %h want 000000033", {stall, r_wdata}); end
    tick();
    idle_inputs();
  endtask

  task automatic test_invalid_channel();
    io_read = 1; m_read = 1; addr_in = 32'hFFFF_FC54; mem_rdata = 32'hDEAD;
    #1;
    n_checks++; if ({stall, bus_err} !== 2'b10) begin n_fail++; $display("FAIL inv_c0: got stall/bus_err %b want 10", {stall, bus_err}); end
    tick();
    n_checks++; if ({stall, ch_req, r_wdata} !== 37'd0) begin n_fail++; $display("FAIL inv_done: got %h want 0", {stall, ch_req, r_wdata}); end
    n_checks++; if ({bus_err, err_ch} !== 5'b1_0101) begin n_fail++; $display("FAIL inv_err: got %b want 10101", {bus_err, err_ch}); end
    tick();
    addr_in = 32'hFFFF_FC74;
    tick();
    tick();
    idle_inputs();
    #1;
    n_checks++; if ({bus_err, err_ch} !== 5'b1_0101) begin n_fail++; $display("FAIL inv_err_sticky: got %b want 10101", {bus_err, err_ch}); end
  endtask

  // Read on channel 3 that is never acknowledged.
  task automatic test_no_ack(input logic [3:0] exp_err_ch);
    io_read = 1; addr_in = 32'hFFFF_FC30;
`ifdef MEMIO_TIMEOUT_EN
    for (int c = 1; c <= 15; c++) begin
      tick();
      n_checks++; if ({stall, ch_req} !== 5'b1_1000) begin n_fail++; $display("FAIL tmo_req_c%0d: got %b want 11000", c, {stall, ch_req}); end
    end
    tick();
    n_checks++; if ({stall, ch_req, r_wdata} !== 37'd0) begin n_fail++; $display("FAIL tmo_done: got %h want 0", {stall, ch_req, r_wdata}); end
    n_checks++; if ({bus_err, err_ch} !== {1'b1, exp_err_ch}) begin n_fail++; $display("FAIL tmo_err: got %b want 1%b", {bus_err, err_ch}, exp_err_ch); end
    tick();
    idle_inputs();
`else
    for (int c = 1; c <= 40; c++) tick();
    n_checks++; if ({stall, ch_req} !== 5'b1_1000) begin n_fail++; $display("FAIL noack_wait: got %b want 11000", {stall, ch_req}); end
    n_checks++; if ({bus_err, err_ch} !== {1'b1, exp_err_ch}) begin n_fail++; $display("FAIL noack_err: got %b want 1%b", {bus_err, err_ch}, exp_err_ch); end
    rst = 1'b1;
    idle_inputs();
    tick();
    rst = 1'b0;
    tick();
`endif
  endtask

  task automatic test_reset_mid_req();
    io_read = 1; addr_in = 32'hFFFF_FC24;
    tick();
    n_checks++; if ({stall, ch_req} !== 5'b1_0100) begin n_fail++; $display("FAIL rmr_req: got %b want 10100", {stall, ch_req}); end
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if ({stall, ch_req} !== 5'b0_0000) begin n_fail++; $display("FAIL rmr_async: got %b want 00000", {stall, ch_req}); end
    tick();
    idle_inputs();
    rst = 1'b0;
    tick();
    n_checks++; if ({stall, ch_req, bus_err, err_ch} !== 10'd0) begin n_fail++; $display("FAIL rmr_after: got %b want 0", {stall, ch_req, bus_err, err_ch}); end
    io_read = 1; addr_in = 32'hFFFF_FC14;
    tick();
    n_checks++; if ({stall, ch_req} !== 5'b1_0010) begin n_fail++; $display("FAIL rmr_restart: got %b want 10010", {stall, ch_req}); end
    ch_ack = 4'b0010;
    tick();
    idle_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_mem_access();
    test_io_read();
    test_io_write();
    test_back_to_back();
    test_invalid_channel();
    test_no_ack(4'd5);
    test_reset_mid_req();
`ifdef MEMIO_TIMEOUT_EN
    test_no_ack(4'd3);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
